// File: rtl/lcd_disp_pkg.sv
// ---------------------------------------------------------------------------
// lcd_disp_pkg
//   Shared definitions for the LCD window display path: coordinate widths,
//   the signed working type used for window arithmetic, the latched window
//   geometry record, colour constants and a small clamp helper.
// ---------------------------------------------------------------------------
package lcd_disp_pkg;

  // Width of the pixel coordinates produced by lcd_driver.
  localparam int COORD_W = 11;
  // One extra bit so that lead-in and border arithmetic can go negative
  // without wrapping.
  localparam int CALC_W  = COORD_W + 1;

  // RGB565 colour constants.
  localparam logic [15:0] BLACK = 16'h0000;
  localparam logic [15:0] WHITE = 16'hFFFF;

  typedef logic signed [CALC_W-1:0] calc_t;

  // Window origin, captured once per frame at pixel (0,0).
  typedef struct packed {
    logic [COORD_W-1:0] x0;
    logic [COORD_W-1:0] y0;
  } win_geom_t;

  // Zero-extends an unsigned coordinate into the signed working type.
  function automatic calc_t to_calc(input logic [COORD_W-1:0] v);
    return calc_t'({1'b0, v});
  endfunction

  // min(max(v, lo), hi) on unsigned coordinates; callers guarantee lo <= hi.
  function automatic logic [COORD_W-1:0] clamp_coord(
    input logic [COORD_W-1:0] v,
    input logic [COORD_W-1:0] lo,
    input logic [COORD_W-1:0] hi
  );
    logic [COORD_W-1:0] r;
    r = (v < lo) ? lo : v;
    r = (r > hi) ? hi : r;
    return r;
  endfunction

endpackage

// File: rtl/lcd_valid_delay.sv
// ---------------------------------------------------------------------------
// lcd_valid_delay
//   DEPTH-stage single-bit shift register used to align a request strobe with
//   data that comes back DEPTH cycles later.
//
//   Ports:
//     clk    in   clock
//     rst_n  in   asynchronous active-low reset, clears every stage
//     d_i    in   strobe entering the pipe
//     q_o    out  strobe delayed by exactly DEPTH cycles
// ---------------------------------------------------------------------------
module lcd_valid_delay #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] pipe_q;
  logic [DEPTH-1:0] pipe_d;

  // NOTE: every bit of pipe_d is given a value before any conditional logic,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    pipe_d    = '0;
    pipe_d[0] = d_i;
    for (int i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // NOTE: state is updated with non-blocking assignments so that every stage
  // samples the previous value of its neighbour on the same edge.
  // NOTE: every stage is reset rather than left to flush: a stale 1 left in
  // the pipe would release a phantom pixel straight after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/lcd_window_display.sv
// ---------------------------------------------------------------------------
// lcd_window_display
//   Places an H_IMG x V_IMG camera window on the H_LCD x V_LCD raster, either
//   centred or at runtime offsets latched once per frame. Pixel requests are
//   issued RD_LATENCY columns ahead of the window so that returned data lines
//   up with the raster, an optional BORDER_W frame is drawn around the window,
//   and everything else shows BG_COLOR.
//
//   Ports:
//     lcd_clk      in   pixel clock
//     sys_rst_n    in   asynchronous active-low reset
//     pixel_xpos   in   current LCD column
//     pixel_ypos   in   current LCD row
//     cfg_center   in   1 = centre the window, 0 = use cfg_x_off/cfg_y_off
//     cfg_x_off    in   requested window left column
//     cfg_y_off    in   requested window top row
//     cmos_data    in   pixel returned RD_LATENCY cycles after data_req
//     data_req     out  request for the next image pixel
//     lcd_data     out  pixel to the LCD
//     frame_start  out  one-cycle pulse after a new geometry is latched
// ---------------------------------------------------------------------------
module lcd_window_display
  import lcd_disp_pkg::*;
#(
  parameter int                DATA_W       = 16,
  parameter int                H_LCD        = 800,
  parameter int                V_LCD        = 480,
  parameter int                H_IMG        = 640,
  parameter int                V_IMG        = 480,
  parameter int                RD_LATENCY   = 1,
  parameter int                BORDER_W     = 0,
  parameter logic [DATA_W-1:0] BG_COLOR     = DATA_W'(BLACK),
  parameter logic [DATA_W-1:0] BORDER_COLOR = DATA_W'(WHITE)
) (
  input  logic               lcd_clk,
  input  logic               sys_rst_n,
  input  logic [COORD_W-1:0] pixel_xpos,
  input  logic [COORD_W-1:0] pixel_ypos,
  input  logic               cfg_center,
  input  logic [COORD_W-1:0] cfg_x_off,
  input  logic [COORD_W-1:0] cfg_y_off,
  input  logic [DATA_W-1:0]  cmos_data,
  output logic               data_req,
  output logic [DATA_W-1:0]  lcd_data,
  output logic               frame_start
);

  // -------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // -------------------------------------------------------------------------
  if (RD_LATENCY < 1 || RD_LATENCY > 8) begin : g_bad_latency
    $error("lcd_window_display: RD_LATENCY must be in 1..8");
  end

  // The window may not start before column RD_LATENCY, so the image plus its
  // lead-in has to fit on one LCD line.
  if (H_IMG + RD_LATENCY > H_LCD) begin : g_bad_width
    $error("lcd_window_display: H_IMG + RD_LATENCY exceeds H_LCD");
  end

  if (V_IMG > V_LCD) begin : g_bad_height
    $error("lcd_window_display: V_IMG exceeds V_LCD");
  end

  // -------------------------------------------------------------------------
  // Constants
  // -------------------------------------------------------------------------
  localparam logic [COORD_W-1:0] X_CTR = COORD_W'((H_LCD - H_IMG) / 2);
  localparam logic [COORD_W-1:0] Y_CTR = COORD_W'((V_LCD - V_IMG) / 2);
  localparam logic [COORD_W-1:0] X_MIN = COORD_W'(RD_LATENCY);
  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(H_LCD - H_IMG);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(V_LCD - V_IMG);

  localparam calc_t LAT_C   = calc_t'(RD_LATENCY);
  localparam calc_t H_IMG_C = calc_t'(H_IMG);
  localparam calc_t V_IMG_C = calc_t'(V_IMG);
  localparam calc_t H_LCD_C = calc_t'(H_LCD);
  localparam calc_t V_LCD_C = calc_t'(V_LCD);
  localparam calc_t BRD_C   = calc_t'(BORDER_W);
  localparam calc_t ZERO_C  = calc_t'(0);

  localparam logic BORDER_EN = (BORDER_W > 0);

  localparam win_geom_t GEOM_CTR = '{x0: X_CTR, y0: Y_CTR};

  // -------------------------------------------------------------------------
  // Geometry latch: only at pixel (0,0), so mid-frame configuration changes
  // never tear the current frame.
  // -------------------------------------------------------------------------
  win_geom_t geom_q;
  win_geom_t geom_d;
  logic      frame_start_q;
  logic      at_origin;

  assign at_origin = (pixel_xpos == '0) && (pixel_ypos == '0);

  always_comb begin
    geom_d = geom_q;
    if (at_origin) begin
      if (cfg_center) begin
        geom_d = GEOM_CTR;
      end else begin
        geom_d.x0 = clamp_coord(cfg_x_off, X_MIN, X_MAX);
        geom_d.y0 = clamp_coord(cfg_y_off, '0, Y_MAX);
      end
    end
  end

  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      geom_q        <= GEOM_CTR;
      frame_start_q <= 1'b0;
    end else begin
      geom_q        <= geom_d;
      frame_start_q <= at_origin;
    end
  end

  assign frame_start = frame_start_q;

  // -------------------------------------------------------------------------
  // Window decode in signed working precision
  // -------------------------------------------------------------------------
  calc_t pix_x;
  calc_t pix_y;
  calc_t win_x0;
  calc_t win_y0;

  assign pix_x  = to_calc(pixel_xpos);
  assign pix_y  = to_calc(pixel_ypos);
  assign win_x0 = to_calc(geom_q.x0);
  assign win_y0 = to_calc(geom_q.y0);

  logic win_rows;
  logic req_cols;
  logic win_cols;
  logic in_window;

  assign win_rows  = (pix_y >= win_y0) && (pix_y < win_y0 + V_IMG_C);
  // Request columns lead the window by RD_LATENCY so data lands on win_x0.
  assign req_cols  = (pix_x >= win_x0 - LAT_C) &&
                     (pix_x <  win_x0 + H_IMG_C - LAT_C);
  assign win_cols  = (pix_x >= win_x0) && (pix_x < win_x0 + H_IMG_C);
  assign in_window = win_rows && win_cols;

  // The geometry is combinational from registers, so reset has to gate the
  // request directly for it to drop the instant sys_rst_n falls.
  assign data_req = sys_rst_n && win_rows && req_cols;

  // -------------------------------------------------------------------------
  // Request-to-data alignment
  // -------------------------------------------------------------------------
  logic data_val;

  lcd_valid_delay #(
    .DEPTH (RD_LATENCY)
  ) u_valid_delay (
    .clk   (lcd_clk),
    .rst_n (sys_rst_n),
    .d_i   (data_req),
    .q_o   (data_val)
  );

  // -------------------------------------------------------------------------
  // Border: window rectangle grown by BORDER_W, clipped to the LCD.
  // -------------------------------------------------------------------------
  calc_t brd_x_lo;
  calc_t brd_x_hi;
  calc_t brd_y_lo;
  calc_t brd_y_hi;
  logic  in_expanded;
  logic  border_hit;

  always_comb begin
    brd_x_lo = win_x0 - BRD_C;
    brd_y_lo = win_y0 - BRD_C;
    if (brd_x_lo < ZERO_C) begin
      brd_x_lo = ZERO_C;
    end
    if (brd_y_lo < ZERO_C) begin
      brd_y_lo = ZERO_C;
    end
    brd_x_hi = win_x0 + H_IMG_C + BRD_C;
    brd_y_hi = win_y0 + V_IMG_C + BRD_C;
  end

  assign in_expanded = (pix_x >= brd_x_lo) && (pix_x < brd_x_hi) && (pix_x < H_LCD_C) &&
                       (pix_y >= brd_y_lo) && (pix_y < brd_y_hi) && (pix_y < V_LCD_C);

  // Gated by reset so the output is pure background while reset is held.
  assign border_hit = BORDER_EN && sys_rst_n && in_expanded && !in_window;

  // -------------------------------------------------------------------------
  // Output mux: image, then border, then background.
  // -------------------------------------------------------------------------
  always_comb begin
    lcd_data = BG_COLOR;
    if (data_val) begin
      lcd_data = cmos_data;
    end else if (border_hit) begin
      lcd_data = BORDER_COLOR;
    end
  end

endmodule

// File: doc/lcd_window_display.md
Name: lcd_window_display

Overview:
- Places a camera image window of configurable size and position on the LCD raster. The window is either centred or set by runtime offsets.
- Issues pixel requests early to match a parametrised read latency, and draws an optional coloured frame border. Everything outside the window and border is background.
- Sits between lcd_driver (pixel_xpos/ypos source) and the SDRAM/FIFO read port that returns cmos_data. Successor to the fixed 1-cycle, horizontal-only centring display block.

Parameters:
- DATA_W, 16, pixel width (RGB565).
- H_LCD, 800, LCD active width.
- V_LCD, 480, LCD active height.
- H_IMG, 640, image width.
- V_IMG, 480, image height.
- RD_LATENCY, 1, cycles from data_req high to cmos_data valid; range 1..8.
- BORDER_W, 0, border thickness in pixels drawn outside the window; 0 disables the border.
- BG_COLOR, 16'h0000, background colour.
- BORDER_COLOR, 16'hFFFF, border colour.

Ports:
- lcd_clk  in  1  pixel clock
- sys_rst_n  in  1  asynchronous active-low reset
- pixel_xpos  in  11  current LCD column
- pixel_ypos  in  11  current LCD row
- cfg_center  in  1  1 = centre window, 0 = use cfg_x_off/cfg_y_off
- cfg_x_off  in  11  requested window left column
- cfg_y_off  in  11  requested window top row
- cmos_data  in  DATA_W  pixel returned RD_LATENCY cycles after each data_req
- data_req  out  1  request next image pixel
- lcd_data  out  DATA_W  pixel to LCD
- frame_start  out  1  one-cycle pulse when a new window geometry is latched

Behaviour:
- Single clock domain. Reset is asynchronous and active-low on sys_rst_n.
- Reset values:
  - All registers return to these values immediately on reset assertion, including mid-line or mid-frame.
  - data_req = 0, frame_start = 0, valid pipe = 0.
  - lcd_data = BG_COLOR, because the valid pipe is 0.
  - win_x0/win_y0 hold the centred values (H_LCD-H_IMG)/2 and (V_LCD-V_IMG)/2.
- Geometry latch:
  - Occurs when pixel_xpos==0 and pixel_ypos==0, and at no other time.
  - Register win_x0 and win_y0 from the config inputs and pulse frame_start for one cycle.
  - If cfg_center=1, use the centred values.
  - Otherwise clamp: win_x0 = min(max(cfg_x_off, RD_LATENCY), H_LCD-H_IMG) and win_y0 = min(cfg_y_off, V_LCD-V_IMG).
  - Config changes mid-frame take effect only at the next latch; no tearing.
- Request:
  - data_req is combinational from registered geometry.
  - It is high when pixel_ypos is in [win_y0, win_y0+V_IMG) and pixel_xpos is in [win_x0-RD_LATENCY, win_x0+H_IMG-RD_LATENCY).
  - This gives exactly H_IMG requests per image line and V_IMG lines per frame.
- Valid pipeline:
  - A shift register of depth RD_LATENCY carries data_req.
  - Its output, data_val, is high exactly for xpos in [win_x0, win_x0+H_IMG) on window rows.
- Output mux (combinational, priority order):
  1. data_val -> cmos_data.
  2. Else, if BORDER_W>0 and the pixel lies in the window rectangle expanded by BORDER_W on each side (clipped to the LCD) but is not inside the window -> BORDER_COLOR.
  3. Else -> BG_COLOR.
- Arithmetic: 12-bit internal signed or extended compares, so that win_x0-RD_LATENCY and the border expansion never wrap. Border coordinates below 0 clip to 0.
- Boundary cases:
  - If H_IMG==H_LCD, the clamp forces win_x0 ≥ RD_LATENCY and the generate check fails elaboration, because no room is left for lead-in. Use a $error when H_IMG+RD_LATENCY > H_LCD.
  - V_IMG==V_LCD is legal (win_y0=0).
  - Line wrap: the valid pipe drains naturally; no request crosses a line end.

Decomposition:
- Package lcd_disp_pkg holds colour constants (BLACK, WHITE) and the coordinate width localparam (11).
- One sub-module, lcd_valid_delay: a parametrised DEPTH shift register with async reset, reusable for other latency alignment.

Test Plan:
- Defaults, cfg_center=1, one frame:
  - data_req high for xpos 79..718 on rows 0..479.
  - lcd_data equals cmos_data for xpos 80..719 and BG (0x0000) at xpos 79 and 720.
  - 640 requests per line.
- RD_LATENCY=3, cfg_center=0, cfg_x_off=100, cfg_y_off=50, V_IMG=240:
  - req at xpos 97..736 on rows 50..289.
  - Image pixels appear at xpos 100..739.
  - Row 49 and row 290 are fully BG.
- Clamp: cfg_x_off=500 -> win_x0=160. cfg_x_off=0 with RD_LATENCY=3 -> win_x0=3. cfg_y_off=400, V_IMG=240 -> win_y0=240.
- Border, BORDER_W=2, centred, V_IMG=240:
  - BORDER_COLOR at xpos 78..79 and 720..721 on rows 118..361.
  - Full rows 118, 119, 360 and 361 carry BORDER_COLOR over xpos 78..721.
  - Image area unchanged.
- Change cfg_x_off mid-frame at row 200:
  - Request columns unchanged until the next (0,0).
  - frame_start pulses exactly once per frame.
- Assert sys_rst_n low at row 100, xpos 300:
  - data_req=0 and lcd_data=BG immediately.
  - After release, geometry is centred and normal output resumes from the next qualifying pixel.
